// File: rtl/uart_cmd_bridge.sv
`default_nettype none
// ============================================================================
// Module   : uart_cmd_bridge
// Brief    : Stages UART command/page bytes into shared RAM, kicks the NAND
//            controller, then streams readback data and a status byte.
// Revision : 1.0  initial release
// ============================================================================
module uart_cmd_bridge #(
  parameter int CMD_SIZE   = 7,
  parameter int DATA_BASE  = 8,
  parameter int PAGE_BYTES = 2112,
  parameter int TIMEOUT    = 1000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic [7:0]  tx_data,
  output logic        tx_start,
  input  logic        tx_busy,
  output logic [11:0] ram_addr,
  output logic [7:0]  ram_wdata,
  output logic        ram_we,
  output logic        ram_re,
  input  logic [7:0]  ram_rdata,
  output logic        ram_own,
  output logic        ready,
  input  logic        comm_done,
  output logic        busy
);

  localparam logic [7:0]  c_OP_PROG   = 8'h50;
  localparam logic [7:0]  c_OP_READ   = 8'h52;
  localparam logic [7:0]  c_OP_ERASE  = 8'h45;
  localparam logic [7:0]  c_RSP_ACK   = 8'h4B;
  localparam logic [7:0]  c_RSP_ERR   = 8'h3F;
  localparam logic [11:0] c_CMD_LAST  = 12'(CMD_SIZE - 1);
  localparam logic [11:0] c_DATA_BASE = 12'(DATA_BASE);
  localparam logic [11:0] c_DATA_LAST = 12'(DATA_BASE + PAGE_BYTES - 1);
  localparam logic [11:0] c_PAGE_LAST = 12'(PAGE_BYTES - 1);
  localparam logic [23:0] c_TMO_LAST  = 24'(TIMEOUT - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_CMD_RX, S_DATA_RX, S_START, S_WAIT_DONE, S_TX_RD,
    S_TX_LATCH, S_TX_SEND, S_TX_WAIT, S_ACK_SEND, S_ACK_WAIT
  } state_t;

  state_t      r_state, w_next;
  logic [11:0] r_waddr, r_ram_addr, r_cnt;
  logic [7:0]  r_wdata, r_op, r_tx_data;
  logic        r_we;
  logic [23:0] r_tmo;

  logic        w_accept, w_rx_state, w_tmo_hit, w_wr_cmd_last, w_wr_data_last;
  logic        w_tx_load, w_cnt_clr, w_cnt_inc, w_waddr_base;
  logic [7:0]  w_tx_val;

  assign w_rx_state     = (r_state == S_CMD_RX) || (r_state == S_DATA_RX);
  assign w_accept       = rx_valid && ((r_state == S_IDLE) || w_rx_state);
  assign w_tmo_hit      = (r_tmo == c_TMO_LAST) && !rx_valid;
  assign w_wr_cmd_last  = r_we && (r_ram_addr == c_CMD_LAST);
  assign w_wr_data_last = r_we && (r_ram_addr == c_DATA_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next       = r_state;
    w_tx_load    = 1'b0;
    w_tx_val     = c_RSP_ERR;
    w_cnt_clr    = 1'b0;
    w_cnt_inc    = 1'b0;
    w_waddr_base = 1'b0;
    tx_start     = 1'b0;
    case (r_state)
      S_IDLE: if (rx_valid) w_next = S_CMD_RX;
      // Opcode is judged in the cycle the last command byte is written.
      S_CMD_RX: begin
        if (w_wr_cmd_last) begin
          if (r_op == c_OP_PROG) begin
            w_next       = S_DATA_RX;
            w_waddr_base = 1'b1;
          end else if ((r_op == c_OP_READ) || (r_op == c_OP_ERASE)) begin
            w_next = S_START;
          end else begin
            w_next    = S_ACK_SEND;
            w_tx_load = 1'b1;
          end
        end else if (w_tmo_hit) begin
          w_next    = S_ACK_SEND;
          w_tx_load = 1'b1;
        end
      end
      S_DATA_RX: begin
        if (w_wr_data_last) begin
          w_next = S_START;
        end else if (w_tmo_hit) begin
          w_next    = S_ACK_SEND;
          w_tx_load = 1'b1;
        end
      end
      S_START: w_next = S_WAIT_DONE;
      S_WAIT_DONE: begin
        if (comm_done) begin
          if (r_op == c_OP_READ) begin
            w_next    = S_TX_RD;
            w_cnt_clr = 1'b1;
          end else begin
            w_next    = S_ACK_SEND;
            w_tx_load = 1'b1;
            w_tx_val  = c_RSP_ACK;
          end
        end
      end
      S_TX_RD:    w_next = S_TX_LATCH;
      S_TX_LATCH: w_next = S_TX_SEND;
      S_TX_SEND: begin
        if (!tx_busy) begin
          tx_start = 1'b1;
          w_next   = S_TX_WAIT;
        end
      end
      S_TX_WAIT: begin
        if (!tx_busy) begin
          w_cnt_inc = 1'b1;
          if (r_cnt == c_PAGE_LAST) begin
            w_next    = S_ACK_SEND;
            w_tx_load = 1'b1;
            w_tx_val  = c_RSP_ACK;
          end else begin
            w_next = S_TX_RD;
          end
        end
      end
      S_ACK_SEND: begin
        if (!tx_busy) begin
          tx_start = 1'b1;
          w_next   = S_ACK_WAIT;
        end
      end
      S_ACK_WAIT: if (!tx_busy) w_next = S_IDLE;
      default:    w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_waddr    <= '0;
      r_ram_addr <= '0;
      r_wdata    <= '0;
      r_we       <= 1'b0;
      r_op       <= '0;
      r_tmo      <= '0;
      r_cnt      <= '0;
      r_tx_data  <= '0;
    end else begin
      r_we <= w_accept;
      if (w_accept) begin
        r_ram_addr <= r_waddr;
        r_wdata    <= rx_data;
        r_waddr    <= r_waddr + 12'd1;
      end else if (w_waddr_base) begin
        r_waddr <= c_DATA_BASE;
      end else if (w_next == S_IDLE) begin
        r_waddr <= '0;
      end
      if (w_accept && (r_state == S_IDLE)) r_op <= rx_data;
      // Loaded with 1 so the count equals cycles elapsed since the last byte.
      if (w_accept)        r_tmo <= 24'd1;
      else if (w_rx_state) r_tmo <= r_tmo + 24'd1;
      else                 r_tmo <= '0;
      if (w_cnt_clr || (w_next == S_IDLE)) r_cnt <= '0;
      else if (w_cnt_inc)                  r_cnt <= r_cnt + 12'd1;
      if (w_tx_load)                    r_tx_data <= w_tx_val;
      else if (r_state == S_TX_LATCH)   r_tx_data <= ram_rdata;
    end
  end

  assign tx_data   = r_tx_data;
  assign ram_addr  = (r_state == S_TX_RD) ? (c_DATA_BASE + r_cnt) : r_ram_addr;
  assign ram_wdata = r_wdata;
  assign ram_we    = r_we;
  assign ram_re    = (r_state == S_TX_RD);
  assign ram_own   = (r_state != S_START) && (r_state != S_WAIT_DONE);
  assign ready     = (r_state == S_START);
  assign busy      = (r_state != S_IDLE);

endmodule
`default_nettype wire
